cam_capture: RTL

Pixel-capture stage that consumes the YCbCr 4:2:2 byte stream of the OV7670 after the SCCB configuration sequence has completed. It oversamples the camera's pixel clock, sync and data lines in the 100 MHz system domain, packs every 4 bytes into a 32-bit pixel-pair word, and buffers words in a small first-word-fall-through FIFO. A valid/ready stream feeds the downstream encoder, with frame and line markers.

---
 rtl/cam_capture.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/cam_capture.sv
// OV7670 YCbCr 4:2:2 capture: oversampled camera bus, 4-byte word packing,
// first-word-fall-through output FIFO with frame/line markers.
module cam_capture #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sof,
  output logic        out_eol,
  output logic        frame_done,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam int WPL = FRAME_WIDTH / 2;
  localparam int WCW = $clog2(WPL + 1);
  localparam int LCW = $clog2(FRAME_HEIGHT + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam logic [WCW-1:0] WPL_C  = WCW'(WPL);
  localparam logic [WCW-1:0] LAST_W = WCW'(WPL - 1);
  localparam logic [LCW-1:0] H_C    = LCW'(FRAME_HEIGHT);

  typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, DROP} state_t;

  // camera bus synchronizers; the third stage only feeds edge detection
  logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic       vs_s1_q, vs_s2_q, vs_s3_q;
  logic       hr_s1_q, hr_s2_q, hr_s3_q;
  logic [7:0] d_s1_q, d_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {pclk_s3_q, pclk_s2_q, pclk_s1_q} <= '0;
      {vs_s3_q, vs_s2_q, vs_s1_q}       <= '0;
      {hr_s3_q, hr_s2_q, hr_s1_q}       <= '0;
      d_s1_q <= '0;
      d_s2_q <= '0;
    end else begin
      {pclk_s3_q, pclk_s2_q, pclk_s1_q} <= {pclk_s2_q, pclk_s1_q, cam_pclk};
      {vs_s3_q, vs_s2_q, vs_s1_q}       <= {vs_s2_q, vs_s1_q, cam_vsync};
      {hr_s3_q, hr_s2_q, hr_s1_q}       <= {hr_s2_q, hr_s1_q, cam_href};
      d_s1_q <= cam_data;
      d_s2_q <= d_s1_q;
    end
  end

  logic strobe, vs_rise, vs_fall, hr_rise, hr_fall;
  assign strobe  = pclk_s2_q & ~pclk_s3_q;
  assign vs_rise = vs_s2_q & ~vs_s3_q;
  assign vs_fall = ~vs_s2_q & vs_s3_q;
  assign hr_rise = hr_s2_q & ~hr_s3_q;
  assign hr_fall = ~hr_s2_q & hr_s3_q;

  state_t          state_q, state_d;
  logic [1:0]      byte_idx_q, byte_idx_d, idx_eff;
  logic [7:0]      lane0_q, lane0_d, lane1_q, lane1_d, lane2_q, lane2_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic [LCW-1:0]  line_cnt_q, line_cnt_d;
  logic            sof_arm_q, sof_arm_d;
  logic            push_q, push_d, push_sof_q, push_sof_d, push_eol_q, push_eol_d;
  logic [31:0]     push_word_q, push_word_d;
  logic            overflow_q, overflow_d, frame_done_q, frame_done_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [33:0]     fifo_mem_q [FIFO_DEPTH];
  logic            fifo_empty, fifo_full, full_block, push_en, pop, flush;
  logic [33:0]     head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = ~fifo_empty & out_ready;
  // a pop in the same cycle frees the slot the push needs
  assign full_block = fifo_full & ~out_ready;
  assign push_en    = push_q & ~full_block & enable;

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    lane0_d      = lane0_q;
    lane1_d      = lane1_q;
    lane2_d      = lane2_q;
    word_cnt_d   = word_cnt_q;
    line_cnt_d   = line_cnt_q;
    sof_arm_d    = sof_arm_q;
    push_d       = 1'b0;
    push_sof_d   = push_sof_q;
    push_eol_d   = push_eol_q;
    push_word_d  = push_word_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    flush        = 1'b0;
    idx_eff      = hr_rise ? 2'd0 : byte_idx_q;

    if (!enable) begin
      state_d    = WAIT_FRAME;
      byte_idx_d = '0;
      word_cnt_d = '0;
      line_cnt_d = '0;
      sof_arm_d  = 1'b0;
      overflow_d = 1'b0;
      flush      = 1'b1;
    end else begin
      if (push_q && full_block) overflow_d = 1'b1;
      case (state_q)
        WAIT_FRAME: begin
          if (vs_fall) begin
            state_d    = ACTIVE;
            byte_idx_d = '0;
            word_cnt_d = '0;
            line_cnt_d = '0;
            sof_arm_d  = 1'b1;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            state_d      = WAIT_FRAME;
          end else if (push_q && full_block) begin
            state_d = DROP;
          end else begin
            if (hr_rise || hr_fall) byte_idx_d = '0;
            if (hr_fall && word_cnt_q != '0) begin
              word_cnt_d = '0;
              if (line_cnt_q < H_C) line_cnt_d = line_cnt_q + LCW'(1);
            end
            if (strobe && hr_s2_q) begin
              byte_idx_d = idx_eff + 2'd1;
              case (idx_eff)
                2'd0: lane0_d = d_s2_q;
                2'd1: lane1_d = d_s2_q;
                2'd2: lane2_d = d_s2_q;
                default: begin
                  if (word_cnt_q < WPL_C && line_cnt_q < H_C) begin
                    push_d      = 1'b1;
                    push_word_d = {d_s2_q, lane2_q, lane1_q, lane0_q};
                    push_sof_d  = sof_arm_q;
                    push_eol_d  = (word_cnt_q == LAST_W);
                    sof_arm_d   = 1'b0;
                    word_cnt_d  = word_cnt_q + WCW'(1);
                  end
                end
              endcase
            end
          end
        end
        DROP: begin
          if (vs_rise) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            state_d      = WAIT_FRAME;
          end
        end
        default: state_d = WAIT_FRAME;
      endcase
    end

    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push_en);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_FRAME;
      byte_idx_q   <= '0;
      lane0_q      <= '0;
      lane1_q      <= '0;
      lane2_q      <= '0;
      word_cnt_q   <= '0;
      line_cnt_q   <= '0;
      sof_arm_q    <= 1'b0;
      push_q       <= 1'b0;
      push_sof_q   <= 1'b0;
      push_eol_q   <= 1'b0;
      push_word_q  <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      lane0_q      <= lane0_d;
      lane1_q      <= lane1_d;
      lane2_q      <= lane2_d;
      word_cnt_q   <= word_cnt_d;
      line_cnt_q   <= line_cnt_d;
      sof_arm_q    <= sof_arm_d;
      push_q       <= push_d;
      push_sof_q   <= push_sof_d;
      push_eol_q   <= push_eol_d;
      push_word_q  <= push_word_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {push_sof_q, push_eol_q, push_word_q};
  end

  // head fields read as zero whenever nothing is offered
  assign head        = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid   = ~fifo_empty;
  assign out_data    = out_valid ? head[31:0] : '0;
  assign out_eol     = out_valid & head[32];
  assign out_sof     = out_valid & head[33];
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_cnt_q;

endmodule
